regfile_mp_scoreboard: RTL

//  Next-gen CPU register file: parametrised width/depth, NUM_RD combinational read ports, two write-back

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_scoreboard.sv | 56 +++++
 rtl/regfile_mp_scoreboard.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, write-back port record and bus-slicing helper for the
// multi-port register file with busy scoreboard.
package regfile_pkg;

    localparam int              DEF_DATA_W   = 32;
    localparam int              DEF_ADDR_W   = 4;
    localparam int              DEF_NUM_RD   = 2;
    localparam int              DEF_SP_IDX   = 13;
    localparam logic [31:0]     DEF_SP_RESET = 32'h0000_1000;
    localparam int              DEF_ZERO_IDX = 15;

    // Write-back port record at the default geometry.
    typedef struct packed {
        logic                  en;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_port_t;

    // Bit offset of element k in a flattened bus of w-bit elements.
    function automatic int sel_read(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register, set by accepted issue reservations,
// cleared by accepted write-backs; reservation wins over a same-cycle clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_IDX = DEF_ZERO_IDX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr0_en,
    input  logic [ADDR_W-1:0]        clr0_addr,
    input  logic                     clr1_en,
    input  logic [ADDR_W-1:0]        clr1_addr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic                     iss_ready,
    output logic [NUM_RD-1:0]        rd_busy_raw,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_IDX);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_iss_set;

    // Only the registered state feeds iss_ready, so write-back never reaches it.
    assign iss_ready = !r_busy[iss_dst] || (iss_dst == ZERO_A);
    assign w_iss_set = iss_valid && iss_ready && (iss_dst != ZERO_A);

    always_comb begin
        w_busy_nxt = r_busy;
        if (clr0_en)   w_busy_nxt[clr0_addr] = 1'b0;
        if (clr1_en)   w_busy_nxt[clr1_addr] = 1'b0;
        if (w_iss_set) w_busy_nxt[iss_dst]   = 1'b1;
        w_busy_nxt[ZERO_A] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
        logic [ADDR_W-1:0] w_a;
        assign w_a            = rd_addr[sel_read(k, ADDR_W) +: ADDR_W];
        assign rd_busy_raw[k] = r_busy[w_a] && (w_a != ZERO_A);
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Register file: NUM_RD combinational reads, two write-back ports (wr1 wins),
// busy scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                NUM_RD   = DEF_NUM_RD,
    parameter int                SP_IDX   = DEF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(DEF_SP_RESET),
    parameter int                ZERO_IDX = DEF_ZERO_IDX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    output logic                     iss_ready,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_IDX);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    wb_t               w_wb0;
    wb_t               w_wb1;
    logic [NUM_RD-1:0] w_busy_raw;

    // The enable already excludes the zero index, so it means "write accepted".
    assign w_wb0 = '{en: wr0_en && (wr0_addr != ZERO_A), addr: wr0_addr, data: wr0_data};
    assign w_wb1 = '{en: wr1_en && (wr1_addr != ZERO_A), addr: wr1_addr, data: wr1_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
        end else begin
            if (w_wb0.en) r_regs[w_wb0.addr] <= w_wb0.data;
            if (w_wb1.en) r_regs[w_wb1.addr] <= w_wb1.data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_IDX (ZERO_IDX)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr0_en     (w_wb0.en),
        .clr0_addr   (w_wb0.addr),
        .clr1_en     (w_wb1.en),
        .clr1_addr   (w_wb1.addr),
        .iss_valid   (iss_valid),
        .iss_dst     (iss_dst),
        .rd_addr     (rd_addr),
        .iss_ready   (iss_ready),
        .rd_busy_raw (w_busy_raw),
        .busy_vec    (busy_vec)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_arr;
        logic [DATA_W-1:0] w_d;
        logic              w_b;

        assign w_a   = rd_addr[sel_read(k, ADDR_W) +: ADDR_W];
        assign w_arr = (w_a == ZERO_A) ? '0 : r_regs[w_a];

`ifdef REGFILE_BYPASS_EN
        always_comb begin
            w_d = w_arr;
            w_b = w_busy_raw[k];
            if (w_wb1.en && (w_wb1.addr == w_a)) begin
                w_d = w_wb1.data;
                w_b = 1'b0;
            end else if (w_wb0.en && (w_wb0.addr == w_a)) begin
                w_d = w_wb0.data;
                w_b = 1'b0;
            end
        end
`else
        assign w_d = w_arr;
        assign w_b = w_busy_raw[k];
`endif

        assign rd_data[sel_read(k, DATA_W) +: DATA_W] = w_d;
        assign rd_busy[k]                             = w_b;
    end

endmodule
